// File: rtl/frame_downloader.sv
// Fetches a W x H frame of 16-bit pixels from SDRAM in fixed-size read bursts and
// streams them into the 17-bit store queue, tagging the first pixel with bit 16.
module frame_downloader #(
    parameter int          MEMORY_BURST = 32,
    parameter int          FRAME_WIDTH  = 23,
    parameter int          FRAME_HEIGHT = 17,
    parameter logic [20:0] BASE_ADDR    = 21'h34E,
    parameter int          RD_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_done_i,
    input  logic        start_i,
    output logic        cmd_o,
    output logic        cmd_en_o,
    output logic [20:0] addr_o,
    input  logic [31:0] rd_data_i,
    input  logic        rd_data_valid_i,
    output logic        store_wr_en_o,
    input  logic        store_queue_full_i,
    output logic [16:0] store_queue_data_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        error_o,
    output logic [2:0]  dbg_state_o
);

    localparam int BEATS  = MEMORY_BURST / 4;
    localparam int PPB    = MEMORY_BURST / 2;
    localparam int N_PIX  = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int CNT_W  = $clog2(N_PIX + 1);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int SLOT_W = $clog2(PPB);
    localparam int VLD_W  = $clog2(PPB + 1);
    localparam int TO_W   = $clog2(RD_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] N_C   = CNT_W'(N_PIX);
    localparam logic [VLD_W-1:0] PPB_V = VLD_W'(PPB);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_RECV  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q;
    logic              cmd_en_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              error_q;
    logic [20:0]       addr_q;
    logic [CNT_W-1:0]  pix_cnt_q;
    logic [BEAT_W-1:0] beat_q;
    logic [VLD_W-1:0]  rd_ptr_q;
    logic [VLD_W-1:0]  valid_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [15:0]       pix_buf_q [PPB];

    logic [CNT_W-1:0]  remaining;
    logic [VLD_W-1:0]  valid_d;
    logic              pending;
    logic              wr_fire;
    logic              last_wr;
    logic              last_beat;
    logic              sof;

    always_comb begin
        remaining = N_C - pix_cnt_q;
        valid_d   = (remaining >= CNT_W'(PPB)) ? PPB_V : remaining[VLD_W-1:0];
        pending   = (state_q == S_DRAIN) && (rd_ptr_q < valid_q);
        wr_fire   = pending && !store_queue_full_i;
        last_wr   = wr_fire && ((rd_ptr_q + VLD_W'(1)) == valid_q);
        last_beat = rd_data_valid_i && (beat_q == BEAT_W'(BEATS - 1));
        sof       = (pix_cnt_q == '0) && (rd_ptr_q == '0);
    end

    assign cmd_o              = 1'b0;
    assign cmd_en_o           = cmd_en_q;
    assign addr_o             = addr_q;
    assign store_wr_en_o      = wr_fire;
    assign store_queue_data_o = (state_q == S_DRAIN) ? {sof, pix_buf_q[rd_ptr_q[SLOT_W-1:0]]} : 17'd0;
    assign busy_o             = busy_q;
    assign frame_done_o       = frame_done_q;
    assign error_o            = error_q;
    assign dbg_state_o        = state_q;

    // Beat k lands in slots 2k (even pixel) and 2k+1 (odd pixel).
    always_ff @(posedge clk) begin
        if (state_q == S_RECV && rd_data_valid_i) begin
            pix_buf_q[{beat_q, 1'b0}] <= rd_data_i[15:0];
            pix_buf_q[{beat_q, 1'b1}] <= rd_data_i[31:16];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cmd_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= BASE_ADDR;
            pix_cnt_q    <= '0;
            beat_q       <= '0;
            rd_ptr_q     <= '0;
            valid_q      <= '0;
            to_cnt_q     <= '0;
        end else begin
            cmd_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && init_done_i) begin
                        busy_q    <= 1'b1;
                        pix_cnt_q <= '0;
                        addr_q    <= BASE_ADDR;
                        cmd_en_q  <= 1'b1;
                        state_q   <= S_CMD;
                    end
                end
                S_CMD: begin
                    to_cnt_q <= '0;
                    beat_q   <= '0;
                    state_q  <= S_RECV;
                end
                S_RECV: begin
                    // The command cycle counts as the first cycle of the timeout window.
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (rd_data_valid_i) begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                    if (last_beat) begin
                        valid_q  <= valid_d;
                        rd_ptr_q <= '0;
                        state_q  <= S_DRAIN;
                    end else if (to_cnt_q == TO_W'(RD_TIMEOUT - 2)) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (wr_fire) begin
                        rd_ptr_q <= rd_ptr_q + VLD_W'(1);
                    end
                    if (last_wr) begin
                        pix_cnt_q <= pix_cnt_q + CNT_W'(valid_q);
                        if ((pix_cnt_q + CNT_W'(valid_q)) == N_C) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            addr_q       <= BASE_ADDR;
                            state_q      <= S_DONE;
                        end else begin
                            addr_q   <= addr_q + 21'(PPB);
                            cmd_en_q <= 1'b1;
                            state_q  <= S_CMD;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_downloader.sv
// Directed bench for frame_downloader: burst responder, write/command monitors and
// a linear sequence of frame scenarios checked with immediate assertions.
module tb_frame_downloader;

    localparam logic [20:0] BASE_A = 21'h34E;
    localparam int          NPIX   = 391;
    localparam int          NCMD   = 25;

    logic        clk;
    logic        reset_n;
    logic        init_done_i;
    logic        start_i;
    logic        cmd_o;
    logic        cmd_en_o;
    logic [20:0] addr_o;
    logic [31:0] rd_data_i;
    logic        rd_data_valid_i;
    logic        store_wr_en_o;
    logic        store_queue_full_i;
    logic [16:0] store_queue_data_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        error_o;
    logic [2:0]  dbg_state_o;

    frame_downloader dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .init_done_i        (init_done_i),
        .start_i            (start_i),
        .cmd_o              (cmd_o),
        .cmd_en_o           (cmd_en_o),
        .addr_o             (addr_o),
        .rd_data_i          (rd_data_i),
        .rd_data_valid_i    (rd_data_valid_i),
        .store_wr_en_o      (store_wr_en_o),
        .store_queue_full_i (store_queue_full_i),
        .store_queue_data_o (store_queue_data_o),
        .busy_o             (busy_o),
        .frame_done_o       (frame_done_o),
        .error_o            (error_o),
        .dbg_state_o        (dbg_state_o)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory contents: pixel at word address a
    function automatic logic [15:0] pix(input logic [20:0] a);
        return (a[15:0] * 16'd3) + 16'h1234;
    endfunction

    // Monitors, sampled on the falling edge
    logic [20:0] cmd_addr_q [$];
    int          cmd_cyc_q  [$];
    logic        cmd_val_q  [$];
    logic [16:0] wr_q       [$];
    int          wr_cyc_q   [$];
    int          fd_cnt      = 0;
    int          fd_cyc      = 0;
    int          last_wr_cyc = 0;
    int          err_cyc     = 0;
    logic        err_prev    = 1'b0;

    always @(negedge clk) begin
        if (store_wr_en_o) begin
            wr_q.push_back(store_queue_data_o);
            wr_cyc_q.push_back(cyc);
            last_wr_cyc <= cyc;
        end
        if (cmd_en_o) begin
            cmd_addr_q.push_back(addr_o);
            cmd_cyc_q.push_back(cyc);
            cmd_val_q.push_back(cmd_o);
        end
        if (frame_done_o) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
        err_prev <= error_o;
        if (error_o && !err_prev) err_cyc <= cyc;
    end

    // Burst responder: 8 beats starting 3 cycles after each cmd_en
    int resp_total  = 0;
    int withhold_at = -1;

    initial begin : responder
        logic [20:0] ra;
        rd_data_valid_i = 1'b0;
        rd_data_i       = 32'd0;
        forever begin
            @(negedge clk);
            if (cmd_en_o) begin
                ra = addr_o;
                if (resp_total != withhold_at) begin
                    repeat (3) @(posedge clk);
                    #1;
                    for (int k = 0; k < 8; k++) begin
                        rd_data_valid_i = 1'b1;
                        rd_data_i = {pix(21'(ra + 21'(2 * k + 1))), pix(21'(ra + 21'(2 * k)))};
                        @(posedge clk);
                        #1;
                    end
                    rd_data_valid_i = 1'b0;
                    rd_data_i       = 32'd0;
                end
                resp_total++;
            end
        end
    end

    // Driver and checking tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    function automatic int probe(input int which);
        case (which)
            0:       return cmd_addr_q.size();
            1:       return wr_q.size();
            2:       return fd_cnt;
            default: return int'(error_o);
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (probe(which) < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(probe(which) >= target), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd"},    32'(cmd_o),              32'd0);
        chk({tag, "_cmd_en"}, 32'(cmd_en_o),           32'd0);
        chk({tag, "_addr"},   32'(addr_o),             32'h34E);
        chk({tag, "_wr_en"},  32'(store_wr_en_o),      32'd0);
        chk({tag, "_data"},   32'(store_queue_data_o), 32'd0);
        chk({tag, "_busy"},   32'(busy_o),             32'd0);
        chk({tag, "_done"},   32'(frame_done_o),       32'd0);
        chk({tag, "_error"},  32'(error_o),            32'd0);
        chk({tag, "_state"},  32'(dbg_state_o),        32'd0);
    endtask

    task automatic check_frame(input int cb, input int wb, input int fdb, input string tag);
        int          ncmd;
        int          nwr;
        int          ntail;
        logic [16:0] e;
        ncmd = cmd_addr_q.size() - cb;
        nwr  = wr_q.size() - wb;
        chk({tag, "_ncmd"}, 32'(ncmd), 32'(NCMD));
        for (int k = 0; k < NCMD && k < ncmd; k++) begin
            chk({tag, "_cmd_addr"}, 32'(cmd_addr_q[cb + k]), 32'(21'(BASE_A + 21'(16 * k))));
            chk({tag, "_cmd_rd"},   32'(cmd_val_q[cb + k]),  32'd0);
        end
        chk({tag, "_nwr"}, 32'(nwr), 32'(NPIX));
        for (int i = 0; i < NPIX && i < nwr; i++) begin
            e = {(i == 0), pix(21'(BASE_A + 21'(i)))};
            chk({tag, "_pixel"}, 32'(wr_q[wb + i]), 32'(e));
        end
        if (nwr >= NPIX) begin
            chk({tag, "_first_px"}, 32'(wr_q[wb]),            32'h11C1E);
            chk({tag, "_last_px"},  32'(wr_q[wb + NPIX - 1]), 32'h020B0);
        end
        chk({tag, "_ndone"}, 32'(fd_cnt - fdb), 32'd1);
        chk({tag, "_busy"},  32'(busy_o),       32'd0);
        if (ncmd >= NCMD) begin
            chk({tag, "_last_cmd_addr"}, 32'(cmd_addr_q[cb + 24]), 32'h4CE);
            ntail = 0;
            for (int i = wb; i < wr_cyc_q.size(); i++)
                if (wr_cyc_q[i] > cmd_cyc_q[cb + 24]) ntail++;
            chk({tag, "_tail_px"}, 32'(ntail), 32'd7);
        end
        chk({tag, "_done_after_last"}, 32'(fd_cyc), 32'(last_wr_cyc + 1));
    endtask

    // Directed sequence
    initial begin : main
        int cb;
        int wb;
        int fdb;
        reset_n            = 1'b0;
        init_done_i        = 1'b0;
        start_i            = 1'b0;
        store_queue_full_i = 1'b0;

        tick(3);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        tick(2);

        // start ignored while the controller is not initialised
        cb = cmd_addr_q.size();
        pulse_start();
        tick(10);
        chk("no_init_cmd",  32'(cmd_addr_q.size() - cb), 32'd0);
        chk("no_init_busy", 32'(busy_o),                 32'd0);
        init_done_i = 1'b1;
        tick(1);

        // Frame A: full frame, plus a start during RECV of burst 0
        cb = cmd_addr_q.size(); wb = wr_q.size(); fdb = fd_cnt;
        pulse_start();
        chk("A_busy", 32'(busy_o), 32'd1);
        wait_for(0, cb + 1, 20, "A_first_cmd");
        tick(3);
        chk("A_in_recv", 32'(dbg_state_o), 32'd2);
        pulse_start();
        wait_for(2, fdb + 1, 3000, "A_done_seen");
        tick(20);
        check_frame(cb, wb, fdb, "A");

        // Frame B: store queue full for 20 cycles after pixel 5 of burst 2
        cb = cmd_addr_q.size(); wb = wr_q.size(); fdb = fd_cnt;
        pulse_start();
        wait_for(1, wb + 37, 3000, "B_reach_px37");
        store_queue_full_i = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            chk("B_stall_wr_en",  32'(store_wr_en_o), 32'd0);
            chk("B_stall_cmd_en", 32'(cmd_en_o),      32'd0);
        end
        chk("B_stall_state", 32'(dbg_state_o),         32'd3);
        chk("B_stall_count", 32'(wr_q.size() - wb),    32'd37);
        tick(1);
        store_queue_full_i = 1'b0;
        wait_for(2, fdb + 1, 3000, "B_done_seen");
        tick(20);
        check_frame(cb, wb, fdb, "B");

        // Frame C: responder withholds data after cmd 3
        withhold_at = resp_total + 3;
        cb = cmd_addr_q.size(); fdb = fd_cnt;
        pulse_start();
        wait_for(3, 1, 1500, "C_error_seen");
        tick(2);
        chk("C_ncmd",       32'(cmd_addr_q.size() - cb),          32'd4);
        chk("C_cmd3_addr",  32'(cmd_addr_q[cb + 3]),              32'h37E);
        chk("C_err_delay",  32'(err_cyc - cmd_cyc_q[cb + 3]),     32'd64);
        chk("C_error",      32'(error_o),                         32'd1);
        chk("C_busy",       32'(busy_o),                          32'd0);
        tick(40);
        chk("C_no_more_cmd", 32'(cmd_addr_q.size() - cb), 32'd4);
        chk("C_no_done",     32'(fd_cnt - fdb),           32'd0);
        withhold_at = -1;

        // Frame D: restart after timeout; error stays sticky
        cb = cmd_addr_q.size(); wb = wr_q.size(); fdb = fd_cnt;
        pulse_start();
        wait_for(2, fdb + 1, 3000, "D_done_seen");
        tick(20);
        check_frame(cb, wb, fdb, "D");
        chk("D_error_sticky", 32'(error_o), 32'd1);

        // Frame E: reset during RECV of burst 10
        cb = cmd_addr_q.size(); fdb = fd_cnt;
        pulse_start();
        wait_for(0, cb + 11, 3000, "E_burst10");
        tick(3);
        chk("E_in_recv", 32'(dbg_state_o), 32'd2);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("E_reset");
        wb = wr_q.size();
        tick(3);
        reset_n = 1'b1;
        tick(15);
        chk("E_stray_writes", 32'(wr_q.size() - wb),       32'd0);
        chk("E_stray_cmds",   32'(cmd_addr_q.size() - cb), 32'd11);
        chk("E_busy",         32'(busy_o),                 32'd0);
        chk("E_no_done",      32'(fd_cnt - fdb),           32'd0);

        // Frame F: clean frame after reset
        cb = cmd_addr_q.size(); wb = wr_q.size(); fdb = fd_cnt;
        pulse_start();
        wait_for(2, fdb + 1, 3000, "F_done_seen");
        tick(20);
        check_frame(cb, wb, fdb, "F");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_downloader.md
Name: frame_downloader

Overview:
- Read-side counterpart of the frame uploader inside VideoController.
- On a frame request it fetches a W×H frame of 16-bit pixels from SDRAM using fixed-size read bursts.
- It unpacks each 32-bit read beat into two pixels and pushes them into the 17-bit store queue.
- It flags the first pixel of the frame with bit 16, matching the uploader's frame-start marker 17'h10000.

Parameters:
- MEMORY_BURST, 32, burst size in bytes; beats per burst = MEMORY_BURST/4 (8), pixels per burst PPB = MEMORY_BURST/2 (16).
- FRAME_WIDTH, 23, pixels per line.
- FRAME_HEIGHT, 17, lines per frame.
- BASE_ADDR, 21'h34E, frame start address in 16-bit word units.
- RD_TIMEOUT, 64, maximum clk cycles between cmd_en and the last beat of the burst.

Ports:
- clk  in  1  controller clock (fb_clk domain).
- reset_n  in  1  asynchronous, active-low reset.
- init_done  in  1  SDRAM controller initialised; start is ignored while low.
- start  in  1  one-cycle frame request.
- cmd  out  1  memory command; always 0 (read) while cmd_en=1.
- cmd_en  out  1  one-cycle command strobe.
- addr  out  21  burst word address.
- rd_data  in  32  read beat; [15:0] = even pixel, [31:16] = odd pixel.
- rd_data_valid  in  1  rd_data qualifier.
- store_wr_en  out  1  store queue write strobe.
- store_queue_full  in  1  store queue full.
- store_queue_data  out  17  {sof, pixel[15:0]}.
- busy  out  1  frame transfer in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is written.
- error  out  1  sticky read-timeout flag; cleared only by reset.

Behaviour:
- Reset values: cmd=0, cmd_en=0, addr=BASE_ADDR, store_wr_en=0, store_queue_data=0, busy=0, frame_done=0, error=0. All counters clear, state=IDLE.
- Derived constants: N = W·H = 391; bursts = ceil(N/PPB) = 25; last burst carries N mod PPB = 7 pixels (PPB if the remainder is 0).

States:
- IDLE: waits for start=1 with init_done=1, then busy←1, pixel counter←0, addr←BASE_ADDR, go to CMD.
  - start is ignored outside IDLE or while init_done=0.
- CMD: drives cmd_en=1 and cmd=0 for exactly one cycle with the current addr; go to RECV. The timeout counter clears.
- RECV: each cycle with rd_data_valid=1 stores the beat into a 16×16 pixel buffer at slots 2k and 2k+1 (k = beat index).
  - After beat MEMORY_BURST/4−1, go to DRAIN.
  - The timeout counter increments each cycle. Reaching RD_TIMEOUT sets error=1, busy=0 and returns to IDLE with no frame_done.
  - rd_data_valid outside RECV is ignored.
- DRAIN: emits valid = min(PPB, N − pixel counter) pixels in slot order.
  - store_wr_en = pending & ~store_queue_full, combinational on full; a write occurs on each clk edge with store_wr_en=1.
  - store_queue_data is driven from the buffer with the read pointer; bit16=1 only for pixel 0 of the frame.
  - Buffer slots at index ≥ valid are never written to the queue: beats are still consumed, their data discarded.
  - When all valid pixels are written, addr += PPB and the pixel counter += valid. If the counter = N, go to DONE, else to CMD.
- DONE: frame_done=1 for one cycle, busy=0, addr←BASE_ADDR, go to IDLE.
- No new cmd_en is issued until the current buffer is fully drained; the buffer therefore never overflows.
- store_queue_full held high stalls DRAIN indefinitely, with no timeout and no data loss.
- Simultaneous start and frame_done: start is ignored (state is not IDLE).
- Reset asserted mid-operation: all outputs return to reset values immediately. Any later rd_data_valid is ignored; no partial frame resumes.
- Width rules:
  - addr is 21-bit, wrapping modulo 2^21.
  - The pixel counter must hold N; use $clog2(N+1) bits.
  - valid is computed with unsigned subtraction; N − counter ≥ 1 is guaranteed inside DRAIN.

Test Plan:
1. Full frame, 23×17, responder returns 8 beats 3 cycles after each cmd_en, full=0.
   - Required: 25 cmd_en pulses, cmd=0, addr=0x34E+16k.
   - Required: 391 store writes matching memory contents, only the first with bit16=1, one frame_done, busy=0 afterwards.
2. Last partial burst:
   - Required: cmd 24 at addr 0x4CE; exactly 7 pixels pushed (beats 0–2 both halves, beat 3 low half); beats 4–7 discarded; frame_done follows the 7th write.
3. Backpressure: store_queue_full high for 20 cycles after the 5th pixel of burst 2.
   - Required: store_wr_en=0 throughout, no cmd_en during the stall, pixel sequence intact and unduplicated.
4. Timeout: responder withholds rd_data_valid after cmd 3.
   - Required: error=1 exactly RD_TIMEOUT cycles after that cmd_en, busy=0, no frame_done, no further cmd_en; a later start restarts at 0x34E.
5. Ignored requests: start with init_done=0, then start during RECV.
   - Required: no cmd_en from the first; the second causes no restart and no extra frame_done.
6. Reset mid-RECV of burst 10:
   - Required: outputs at reset values within the reset cycle, and stray rd_data_valid is ignored.
   - Required: a new start produces a complete 391-pixel frame from 0x34E with sof on pixel 0.
